// File: rtl/rom_fetch_arbiter.sv
// Purpose: four-port round-robin arbiter sharing one registered-output ROM among fetch clients.
// Latency: req sampled at edge k -> rom_cen at k, ROM sample at k+1, ack/data at k+2.
// Backpressure: none toward the ROM; clients wait on ack, one grant per edge, 1 read/cycle sustained.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   req[3:0], addr        per-port request level and address (addr held stable while req high)
//   ack[3:0], data        per-port one-cycle data-valid pulse and held read data
//   rom_addr, rom_cen     registered ROM address / clock enable (one read per high cycle)
//   rom_data              ROM output, valid the cycle after rom_cen is sampled
module rom_fetch_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              req,
    input  logic [4*ADDR_WIDTH-1:0] addr,
    output logic [3:0]              ack,
    output logic [4*DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    output logic                    rom_cen,
    input  logic [DATA_WIDTH-1:0]   rom_data
);

    logic [3:0] busy;       // granted, ack not yet returned
    logic [1:0] last_gnt;   // round-robin pointer; search starts at last_gnt+1
    logic [1:0] cen_id;     // port that owns the read currently on rom_cen
    logic       s1_vld;     // ROM has sampled a read; data arrives at the next edge
    logic [1:0] s1_id;

    logic [3:0] elig;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic [1:0] cand;

    // A port whose ack is high this cycle is excluded so it cannot be
    // re-granted before the client has seen its data.
    assign elig = req & ~busy & ~ack;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = last_gnt;
        cand    = last_gnt;
        for (int i = 1; i <= 4; i++) begin
            cand = last_gnt + 2'(i);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // Grant stage: drive the ROM and record the owner of this read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_cen  <= 1'b0;
            rom_addr <= '0;
            cen_id   <= 2'd0;
            last_gnt <= 2'd3;
        end else begin
            rom_cen <= gnt_vld;
            if (gnt_vld) begin
                rom_addr <= addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                cen_id   <= gnt_id;
                last_gnt <= gnt_id;
            end
        end
    end

    // Tag stage 1: follows rom_cen by one edge, i.e. the edge the ROM samples it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_id  <= 2'd0;
        end else begin
            s1_vld <= rom_cen;
            s1_id  <= cen_id;
        end
    end

    // Tag stage 2: capture ROM output into the owning port and pulse its ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack  <= '0;
            data <= '0;
            busy <= '0;
        end else begin
            ack <= '0;
            if (s1_vld) begin
                ack[s1_id]                          <= 1'b1;
                data[s1_id*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
                busy[s1_id]                         <= 1'b0;
            end
            // A busy port is never eligible, so set and clear never hit the same bit.
            if (gnt_vld) begin
                busy[gnt_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Purpose: directed self-checking bench for rom_fetch_arbiter with a 1-cycle ROM model.
// Latency: checks sampled on the falling edge, inputs driven right after.
// Backpressure: not applicable; ROM model always responds.
module tb_rom_fetch_arbiter;

    localparam int DW = 8;
    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      req = '0;
    logic [4*AW-1:0] addr = '0;
    logic [3:0]      ack;
    logic [4*DW-1:0] data;
    logic [AW-1:0]   rom_addr;
    logic            rom_cen;
    logic [DW-1:0]   rom_data = '0;

    int n_chk  = 0;
    int n_pass = 0;

    rom_fetch_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .addr     (addr),
        .ack      (ack),
        .data     (data),
        .rom_addr (rom_addr),
        .rom_cen  (rom_cen),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // ROM model: every word holds the low byte of its own address.
    always @(posedge clk) begin
        if (rom_cen) rom_data <= rom_addr[7:0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        addr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dbyte(input int p);
        return data[p*DW +: DW];
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        addr    = '0;
        tick();
        chk("rst_ack",  ack,      4'b0000);
        chk("rst_data", data,     32'h0);
        chk("rst_cen",  rom_cen,  1'b0);
        chk("rst_addr", rom_addr, 15'h0);
        tick();
        reset_n = 1'b1;
    endtask

    logic [AW-1:0] fc_a [4];
    logic          rot_cen [8];
    logic [AW-1:0] rot_addr [8];
    int            n_cen, n_ack;

    initial begin
        fc_a     = '{15'h0010, 15'h0020, 15'h0030, 15'h0040};
        rot_cen  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rot_addr = '{15'h0111, 15'h0333, 15'h0, 15'h0, 15'h0111, 15'h0333, 15'h0, 15'h0};

        // ---------------- single port ----------------
        do_reset();
        req = 4'b0100; set_addr(2, 15'h1234);
        tick();
        chk("sp_cen1",  rom_cen,  1'b1);
        chk("sp_addr",  rom_addr, 15'h1234);
        chk("sp_ack1",  ack,      4'b0000);
        tick();
        chk("sp_cen2",  rom_cen,  1'b0);
        chk("sp_ack2",  ack,      4'b0000);
        tick();
        chk("sp_ack3",  ack,      4'b0100);
        chk("sp_data",  dbyte(2), 8'h34);
        req = 4'b0000;
        tick();
        chk("sp_ack4",  ack,      4'b0000);
        chk("sp_hold",  dbyte(2), 8'h34);
        chk("sp_cen4",  rom_cen,  1'b0);

        // ---------------- full contention ----------------
        do_reset();
        req = 4'b1111;
        for (int p = 0; p < 4; p++) set_addr(p, fc_a[p]);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("fc_cen%0d", i),  rom_cen,  1'b1);
            chk($sformatf("fc_addr%0d", i), rom_addr, fc_a[(i-1)%4]);
            if (i >= 3) begin
                chk($sformatf("fc_ack%0d", i),  ack, 4'b0001 << ((i-3)%4));
                chk($sformatf("fc_data%0d", i), dbyte((i-3)%4), fc_a[(i-3)%4][7:0]);
            end else begin
                chk($sformatf("fc_ack%0d", i),  ack, 4'b0000);
            end
        end

        // ---------------- rotation fairness (ports 1 and 3) ----------------
        do_reset();
        req = 4'b1010; set_addr(1, 15'h0111); set_addr(3, 15'h0333);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rot_cen%0d", i), rom_cen, rot_cen[i]);
            if (rot_cen[i]) chk($sformatf("rot_addr%0d", i), rom_addr, rot_addr[i]);
        end

        // ---------------- re-request with new address ----------------
        do_reset();
        req = 4'b0001; set_addr(0, 15'h0001);
        tick();
        chk("rr_cen1",  rom_cen,  1'b1);
        chk("rr_addr1", rom_addr, 15'h0001);
        tick();
        chk("rr_cen2",  rom_cen,  1'b0);
        tick();
        chk("rr_ack3",  ack,      4'b0001);
        chk("rr_data1", dbyte(0), 8'h01);
        set_addr(0, 15'h0002);
        tick();
        chk("rr_cen4",  rom_cen,  1'b0);
        chk("rr_ack4",  ack,      4'b0000);
        tick();
        chk("rr_cen5",  rom_cen,  1'b1);
        chk("rr_addr2", rom_addr, 15'h0002);
        tick();
        req = 4'b0000;
        tick();
        chk("rr_ack7",  ack,      4'b0001);
        chk("rr_data2", dbyte(0), 8'h02);

        // ---------------- early drop ----------------
        do_reset();
        req = 4'b0010; set_addr(1, 15'h0155);
        tick();
        req = 4'b0000;
        chk("ed_cen1",  rom_cen,  1'b1);
        chk("ed_addr",  rom_addr, 15'h0155);
        n_cen = 0; n_ack = 0;
        for (int i = 2; i <= 9; i++) begin
            tick();
            if (rom_cen) n_cen++;
            if (ack != 4'b0000) n_ack++;
            if (i == 3) begin
                chk("ed_ack",  ack,      4'b0010);
                chk("ed_data", dbyte(1), 8'h55);
            end
        end
        chk("ed_ncen", n_cen, 0);
        chk("ed_nack", n_ack, 1);

        // ---------------- reset mid-operation ----------------
        do_reset();
        req = 4'b1000; set_addr(3, 15'h0377);
        tick();
        chk("mr_cen1",  rom_cen,  1'b1);
        chk("mr_addr1", rom_addr, 15'h0377);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mr_ack_r",  ack,      4'b0000);
        chk("mr_data_r", data,     32'h0);
        chk("mr_cen_r",  rom_cen,  1'b0);
        chk("mr_addr_r", rom_addr, 15'h0);
        req = 4'b1001; set_addr(0, 15'h0099);
        tick();
        chk("mr_ack3",  ack,      4'b0000);
        reset_n = 1'b1;
        tick();
        chk("mr_ack4",  ack,      4'b0000);
        chk("mr_cen4",  rom_cen,  1'b1);
        chk("mr_addr4", rom_addr, 15'h0099);
        tick();
        chk("mr_ack5",  ack,      4'b0000);
        chk("mr_addr5", rom_addr, 15'h0377);
        req = 4'b0000;
        tick();
        chk("mr_ack6",  ack,      4'b0001);
        chk("mr_data0", dbyte(0), 8'h99);
        tick();
        chk("mr_ack7",  ack,      4'b1000);
        chk("mr_data3", dbyte(3), 8'h77);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
